// File: rtl/addsub_seq.sv
// Multi-cycle n-bit adder/subtractor: one k-bit slice per clock, start/busy/done handshake.
// Latency n/k cycles after the accepting edge; start is ignored while busy (no queueing).
module addsub_seq #(
    parameter int n = 32,
    parameter int k = 8
) (
    input  logic         Clock,
    input  logic         Resetn,
    input  logic         start,
    input  logic         sub,
    input  logic         carryin,
    input  logic [n-1:0] X,
    input  logic [n-1:0] Y,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] S,
    output logic         carryout,
    output logic         overflow
);

    localparam int SLICES = n / k;
    localparam int CW     = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [CW-1:0] LAST = CW'(SLICES - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state;
    state_t         state_nxt;
    logic [CW-1:0]  cnt;
    logic [n-1:0]   a;
    logic [n-1:0]   b;
    logic           c;
    logic           xm;
    logic           bm;
    logic [k:0]     sum;
    logic [n-1:0]   result;
    logic           last;
    logic           accept;

    assign sum    = {1'b0, a[k-1:0]} + {1'b0, b[k-1:0]} + {{k{1'b0}}, c};
    assign last   = (cnt == LAST);
    assign accept = (state == IDLE) && start;

    // P only needs the n-k bits of slices already produced; the newest slice completes it.
    generate
        if (k < n) begin : g_part
            logic [n-k-1:0] p;
            assign result = {sum[k-1:0], p};
            always_ff @(posedge Clock or negedge Resetn) begin
                if (!Resetn) begin
                    p <= '0;
                end else if (state == RUN) begin
                    p <= result[n-1:k];
                end
            end
        end else begin : g_full
            assign result = sum[k-1:0];
        end
    endgenerate

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            cnt      <= '0;
            a        <= '0;
            b        <= '0;
            c        <= 1'b0;
            xm       <= 1'b0;
            bm       <= 1'b0;
            S        <= '0;
            carryout <= 1'b0;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                a   <= X;
                b   <= sub ? ~Y : Y;
                c   <= sub | carryin;
                xm  <= X[n-1];
                bm  <= sub ? ~Y[n-1] : Y[n-1];
                cnt <= '0;
            end else if (state == RUN) begin
                a   <= a >> k;
                b   <= b >> k;
                c   <= sum[k];
                cnt <= last ? '0 : cnt + 1'b1;
                if (last) begin
                    S        <= result;
                    carryout <= sum[k];
                    overflow <= (xm & bm & ~result[n-1]) | (~xm & ~bm & result[n-1]);
                    done     <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_addsub_seq.sv
// Directed and randomised bench for addsub_seq across four (n,k) configurations.
module tb_addsub_seq;

    typedef struct {
        logic [31:0] s;
        logic        co;
        logic        ov;
        int          lat;
    } exp_t;

    logic        Clock = 1'b0;
    logic        Resetn;
    logic        subd;
    logic        cind;
    logic [31:0] xd;
    logic [31:0] yd;
    logic        start_v [4];
    logic        busy_w  [4];
    logic        done_w  [4];
    logic        co_w    [4];
    logic        ov_w    [4];
    logic [31:0] s_w     [4];
    logic [31:0] s0;
    logic [31:0] s1;
    logic [15:0] s2;
    logic [7:0]  s3;

    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc;

    always #5 Clock = ~Clock;

    addsub_seq #(.n(32), .k(8)) u0 (
        .Clock(Clock), .Resetn(Resetn), .start(start_v[0]), .sub(subd), .carryin(cind),
        .X(xd), .Y(yd), .busy(busy_w[0]), .done(done_w[0]), .S(s0),
        .carryout(co_w[0]), .overflow(ov_w[0]));
    addsub_seq #(.n(32), .k(32)) u1 (
        .Clock(Clock), .Resetn(Resetn), .start(start_v[1]), .sub(subd), .carryin(cind),
        .X(xd), .Y(yd), .busy(busy_w[1]), .done(done_w[1]), .S(s1),
        .carryout(co_w[1]), .overflow(ov_w[1]));
    addsub_seq #(.n(16), .k(4)) u2 (
        .Clock(Clock), .Resetn(Resetn), .start(start_v[2]), .sub(subd), .carryin(cind),
        .X(xd[15:0]), .Y(yd[15:0]), .busy(busy_w[2]), .done(done_w[2]), .S(s2),
        .carryout(co_w[2]), .overflow(ov_w[2]));
    addsub_seq #(.n(8), .k(1)) u3 (
        .Clock(Clock), .Resetn(Resetn), .start(start_v[3]), .sub(subd), .carryin(cind),
        .X(xd[7:0]), .Y(yd[7:0]), .busy(busy_w[3]), .done(done_w[3]), .S(s3),
        .carryout(co_w[3]), .overflow(ov_w[3]));

    assign s_w[0] = s0;
    assign s_w[1] = s1;
    assign s_w[2] = {16'b0, s2};
    assign s_w[3] = {24'b0, s3};

    function automatic exp_t model(int nn, logic [31:0] x, logic [31:0] y, logic sb, logic cin, int lat);
        exp_t        e;
        logic [63:0] mask;
        logic [63:0] bb;
        logic [63:0] tot;
        mask  = (64'd1 << nn) - 64'd1;
        bb    = (sb ? ~{32'b0, y} : {32'b0, y}) & mask;
        tot   = ({32'b0, x} & mask) + bb + {63'b0, (sb | cin)};
        e.s   = tot[31:0] & mask[31:0];
        e.co  = tot[nn];
        e.ov  = (x[nn-1] & bb[nn-1] & ~e.s[nn-1]) | (~x[nn-1] & ~bb[nn-1] & e.s[nn-1]);
        e.lat = lat;
        return e;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Counts negedges (continuing from cyc) until done is seen or the budget runs out.
    task automatic wait_done(int idx);
        while (done_w[idx] !== 1'b1 && cyc < 60) begin
            @(negedge Clock);
            cyc++;
        end
        chk("done_seen", {31'b0, done_w[idx]}, 32'd1);
    endtask

    task automatic pop_check(int idx, string tag);
        exp_t e;
        if (sbq.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sbq.pop_front();
            chk({tag, "_S"},  s_w[idx], e.s);
            chk({tag, "_co"}, {31'b0, co_w[idx]}, {31'b0, e.co});
            chk({tag, "_ov"}, {31'b0, ov_w[idx]}, {31'b0, e.ov});
            if (e.lat >= 0) chk({tag, "_lat"}, cyc - 1, e.lat);
        end
    endtask

    task automatic run_op(int idx, int nn, int kk, logic [31:0] x, logic [31:0] y,
                          logic sb, logic cin, string tag);
        @(negedge Clock);
        xd = x; yd = y; subd = sb; cind = cin;
        start_v[idx] = 1'b1;
        sbq.push_back(model(nn, x, y, sb, cin, nn / kk));
        @(negedge Clock);
        start_v[idx] = 1'b0;
        xd = $urandom; yd = $urandom; subd = $urandom_range(0, 1); cind = $urandom_range(0, 1);
        cyc = 1;
        chk({tag, "_busy"}, {31'b0, busy_w[idx]}, 32'd1);
        wait_done(idx);
        pop_check(idx, tag);
        chk({tag, "_busy_end"}, {31'b0, busy_w[idx]}, 32'd0);
    endtask

    initial begin
        logic seen;
        for (int i = 0; i < 4; i++) start_v[i] = 1'b0;
        xd = '0; yd = '0; subd = 1'b0; cind = 1'b0;
        Resetn = 1'b1;
        #2 Resetn = 1'b0;
        #4;
        chk("rst_S",    s0, 32'd0);
        chk("rst_co",   {31'b0, co_w[0]}, 32'd0);
        chk("rst_ov",   {31'b0, ov_w[0]}, 32'd0);
        chk("rst_busy", {31'b0, busy_w[0]}, 32'd0);
        chk("rst_done", {31'b0, done_w[0]}, 32'd0);
        repeat (2) @(negedge Clock);
        Resetn = 1'b1;

        run_op(0, 32, 8, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, "add_ovf");
        run_op(0, 32, 8, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, "carry_ripple");
        run_op(0, 32, 8, 32'd5,        32'd7,        1'b1, 1'b1, "sub_borrow");
        run_op(0, 32, 8, 32'h80000000, 32'h00000001, 1'b1, 1'b0, "sub_ovf");

        // Second start during RUN must be ignored.
        @(negedge Clock);
        xd = 32'd1; yd = 32'd2; subd = 1'b0; cind = 1'b0;
        start_v[0] = 1'b1;
        sbq.push_back(model(32, 32'd1, 32'd2, 1'b0, 1'b0, 4));
        @(negedge Clock);
        start_v[0] = 1'b0;
        cyc = 1;
        @(negedge Clock);
        cyc++;
        chk("ign_S_stable", s0, 32'h7FFFFFFF);
        xd = 32'd100; start_v[0] = 1'b1;
        @(negedge Clock);
        cyc++;
        start_v[0] = 1'b0;
        wait_done(0);
        pop_check(0, "ign_start");
        seen = 1'b0;
        repeat (8) begin
            @(negedge Clock);
            if (done_w[0] === 1'b1 || busy_w[0] === 1'b1) seen = 1'b1;
        end
        chk("ign_no_second", {31'b0, seen}, 32'd0);
        chk("ign_S_hold", s0, 32'd3);

        // Start held high through done: next op begins right after done.
        @(negedge Clock);
        xd = 32'd10; yd = 32'd20; subd = 1'b0; cind = 1'b0;
        start_v[0] = 1'b1;
        sbq.push_back(model(32, 32'd10, 32'd20, 1'b0, 1'b0, 4));
        @(negedge Clock);
        cyc = 1;
        wait_done(0);
        pop_check(0, "hold1");
        chk("hold_busy_gap", {31'b0, busy_w[0]}, 32'd0);
        xd = 32'd7; yd = 32'd8;
        sbq.push_back(model(32, 32'd7, 32'd8, 1'b0, 1'b0, 4));
        @(negedge Clock);
        start_v[0] = 1'b0;
        chk("hold_busy_again", {31'b0, busy_w[0]}, 32'd1);
        cyc = 1;
        wait_done(0);
        pop_check(0, "hold2");

        // Asynchronous reset in the middle of RUN aborts without done.
        @(negedge Clock);
        xd = 32'h1234; yd = 32'd1; subd = 1'b0; cind = 1'b0;
        start_v[0] = 1'b1;
        @(negedge Clock);
        start_v[0] = 1'b0;
        @(negedge Clock);
        #1 Resetn = 1'b0;
        #1;
        chk("abort_S",    s0, 32'd0);
        chk("abort_busy", {31'b0, busy_w[0]}, 32'd0);
        chk("abort_co",   {31'b0, co_w[0]}, 32'd0);
        chk("abort_ov",   {31'b0, ov_w[0]}, 32'd0);
        seen = 1'b0;
        repeat (3) begin
            @(negedge Clock);
            if (done_w[0] === 1'b1) seen = 1'b1;
        end
        Resetn = 1'b1;
        repeat (6) begin
            @(negedge Clock);
            if (done_w[0] === 1'b1) seen = 1'b1;
        end
        chk("abort_no_done", {31'b0, seen}, 32'd0);
        run_op(0, 32, 8, 32'hDEADBEEF, 32'h01234567, 1'b0, 1'b1, "after_abort");

        // Parameter sweep with random operands.
        for (int r = 0; r < 6; r++)
            run_op(1, 32, 32, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "k32");
        for (int r = 0; r < 6; r++)
            run_op(2, 16, 4, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "n16k4");
        for (int r = 0; r < 6; r++)
            run_op(3, 8, 1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "n8k1");
        run_op(3, 8, 1, 32'h7F, 32'h01, 1'b0, 1'b0, "n8k1_ovf");
        run_op(2, 16, 4, 32'h8000, 32'h0001, 1'b1, 1'b0, "n16k4_subovf");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
